// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative 32-bit divider: state encodings,
// datapath widths, iteration count and ready-flag constants.
package div_unit_pkg;

  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = $clog2(ITER_CNT + 1);

  localparam logic READY     = 1'b1;
  localparam logic NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, shift in the quotient bit.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // The remainder stays below the divisor, so a 33-bit subtract suffices and
  // its top bit is a clean borrow flag.
  assign shifted = {rem_i, quo_i[DATA_W-1]};
  assign diff    = shifted - {1'b0, divisor_i};

  assign rem_o = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], ~diff[DATA_W]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider for the EX stage; result is {remainder, quotient}.
// Signed DIV support is built only when DIV_UNIT_SIGNED_EN is defined.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [RESULT_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic [RESULT_W-1:0]   result_q, result_d;

  logic [DATA_W-1:0]     op1_mag, op2_mag;
  logic [DATA_W-1:0]     step_rem, step_quo;
  logic [RESULT_W-1:0]   final_result;
  logic                  accept;

  assign accept = (state_q == DIV_FREE) && start_i && !annul_i;

`ifdef DIV_UNIT_SIGNED_EN
  logic neg1, neg2;
  logic neg_quo_q, neg_rem_q;

  assign neg1    = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2    = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_mag = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_mag = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

  // Quotient sign follows the operand signs; remainder follows the dividend.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_quo_q <= neg1 ^ neg2;
      neg_rem_q <= neg1;
    end
  end

  assign final_result = {(neg_rem_q ? (~rem_q + 1'b1) : rem_q),
                         (neg_quo_q ? (~quo_q + 1'b1) : quo_q)};
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div_i;
  assign op1_mag           = opdata1_i;
  assign op2_mag           = opdata2_i;
  assign final_result      = {rem_q, quo_q};
`endif

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // NOTE: every output gets its hold value first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;

    unique case (state_q)
      DIV_FREE: begin
        if (accept) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_ON;
            count_d = '0;
            rem_d   = '0;
            quo_d   = op1_mag;
            dvs_d   = op2_mag;
          end
        end
      end

      DIV_BYZERO: begin
        state_d  = annul_i ? DIV_FREE : DIV_END;
        result_d = '0;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
        end else if (count_q == CNT_W'(ITER_CNT)) begin
          state_d  = DIV_END;
          result_d = final_result;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + 1'b1;
        end
      end

      DIV_END: begin
        if (annul_i || !start_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DIV_FREE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == DIV_END) ? READY : NOT_READY;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; expected values are hand-computed.
// Signed expectations apply when DIV_UNIT_SIGNED_EN is defined.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;

  div_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a divide, scramble the inputs after E0, measure latency, check the
  // held result, then release start and check the return to idle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int exp_lat);
    int cyc;
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    tick();
    opdata1_i    = ~a;
    opdata2_i    = b ^ 32'h0000_0005;
    signed_div_i = ~sgn;
    cyc = 0;
    while (!ready_o && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp);
    tick();
    check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_res"}, result_o, exp);
    start_i = 1'b0;
    tick();
    check({tag, "_idle_rdy"}, 64'(ready_o), 64'd0);
    check({tag, "_idle_res"}, result_o, 64'd0);
  endtask

  initial begin
    int seen;
    int cyc;
    reset        = 1'b1;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    annul_i      = 1'b0;
    repeat (3) tick();
    check("reset_rdy", 64'(ready_o), 64'd0);
    check("reset_res", result_o, 64'd0);
    reset = 1'b0;
    tick();

    run_div("u100_7",   32'd100,        32'd7,          1'b0, {32'd2, 32'd14}, 33);
    run_div("u5_10",    32'd5,          32'd10,         1'b0, {32'd5, 32'd0}, 33);
    run_div("umax_1",   32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0, 32'hFFFF_FFFF}, 33);
    run_div("umax_max", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, {32'd0, 32'd1}, 33);
    run_div("u_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'd0}, 33);
    run_div("byzero",   32'd1234,       32'd0,          1'b0, 64'd0, 1);

`ifdef DIV_UNIT_SIGNED_EN
    run_div("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD}, 33);
    run_div("s_m7_m2",  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, {32'hFFFF_FFFF, 32'd3}, 33);
    run_div("s_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000}, 33);
`else
    run_div("nosign_m7_2", 32'hFFFF_FFF9, 32'd2,        1'b1, {32'd1, 32'h7FFF_FFFC}, 33);
    run_div("nosign_min",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'd0}, 33);
`endif

    // Annul while idle keeps the request from being taken.
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    repeat (5) tick();
    check("free_annul_rdy", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    run_div("after_free_annul", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

    // Annul at step 10.
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    tick();
    repeat (10) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul_on_rdy", 64'(ready_o), 64'd0);
    check("annul_on_res", result_o, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) seen++;
    end
    check("annul_on_never_ready", 64'(seen), 64'd0);
    run_div("after_annul", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

    // Reset at step 20.
    start_i   = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    tick();
    repeat (20) tick();
    reset   = 1'b1;
    annul_i = 1'b0;
    tick();
    check("reset_on_rdy", 64'(ready_o), 64'd0);
    check("reset_on_res", result_o, 64'd0);
    reset   = 1'b0;
    start_i = 1'b0;
    tick();
    run_div("after_reset", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

    // Annul while the result is being held.
    start_i   = 1'b1;
    opdata1_i = 32'd20;
    opdata2_i = 32'd4;
    tick();
    cyc = 0;
    while (!ready_o && cyc < 40) begin
      tick();
      cyc++;
    end
    check("end_annul_pre_res", result_o, {32'd0, 32'd5});
    annul_i = 1'b1;
    tick();
    check("end_annul_rdy", 64'(ready_o), 64'd0);
    check("end_annul_res", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Reset while holding a result in END.
    run_div("pre_end_reset", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);
    start_i   = 1'b1;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    tick();
    tick();
    check("byzero_end_rdy", 64'(ready_o), 64'd1);
    reset = 1'b1;
    tick();
    check("end_reset_rdy", 64'(ready_o), 64'd0);
    reset   = 1'b0;
    start_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  EX requests a divide; held high until ready_o has been seen.
REQ-005 signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start_i.
REQ-006 opdata1_i  input  32  dividend; sampled with start_i.
REQ-007 opdata2_i  input  32  divisor; sampled with start_i.
REQ-008 annul_i  input  1  abort; driven from the pipeline-control flush.
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 ready_o  output  1  result_o valid; EX deasserts its stall request when this is seen.

Function
REQ-011 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 FREE, start_i=1, annul_i=0, divisor=0 -> BYZERO; divisor!=0 -> ON, count=0, operands latched.
REQ-013 FREE with annul_i=1 SHALL ignore start_i.
REQ-014 BYZERO SHALL go to END next edge with result = 64'h0.
REQ-015 ON SHALL perform one restoring radix-2 step per edge: 33-bit trial subtract of divisor from the partial remainder, with the quotient bit shifted in.
REQ-016 ON SHALL enter END on the edge after the 32nd step, registering the sign-fixed result.
REQ-017 Latency: the edge that samples start_i is E0; steps occur at E1..E32; ready_o SHALL be high after E33.
REQ-018 ON with annul_i=1 SHALL return to FREE next edge, ready_o=0, result_o=0, with no result produced.
REQ-019 END SHALL drive ready_o=1 and hold result_o stable while start_i=1; start_i=0 -> FREE, ready_o=0, result_o=0 next edge.
REQ-020 annul_i in END SHALL force FREE next edge.
REQ-021 Signed mode: negative operands SHALL be converted to magnitude before iteration.
REQ-022 Signed mode: the quotient SHALL be negated when operand signs differ.
REQ-023 Signed mode: the remainder SHALL take the dividend's sign.
REQ-024 Signed mode: 32'h80000000 / 32'hFFFFFFFF SHALL yield quotient 32'h80000000, remainder 0, with no exception.
REQ-025 Operands SHALL be taken only at the FREE->ON/BYZERO transition; later input changes SHALL have no effect.

Reset
REQ-026 reset=1 SHALL force FREE, count=0, ready_o=0 and result_o=0 on the next edge, including mid-ON and in END.
REQ-027 reset SHALL take priority over annul_i and start_i.

Configuration
REQ-028 With DIV_UNIT_SIGNED_EN defined, signed_div_i SHALL select signed behaviour per REQ-021..REQ-024.
REQ-029 Without DIV_UNIT_SIGNED_EN, signed_div_i SHALL be ignored, all divides SHALL be unsigned, and the sign-fixup logic SHALL be absent.

Structure
REQ-030 The shared package SHALL hold the state encodings (FREE, BYZERO, ON, END), the 32 data width, the 64 result width, the iteration count 32 and the ready/not-ready constants.
REQ-031 The trial-subtract/shift step SHALL be a combinational sub-module div_step, instantiated once.
REQ-032 The FSM, counter and operand/fixup registers SHALL reside in div_unit.

Verification
REQ-033 Unsigned: start_i=1, opdata1=100, opdata2=7 -> ready_o after E33, result_o = {32'd2, 32'd14}.
REQ-034 Signed (macro on): -7 / 2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF; 0x80000000 / -1 -> {0, 32'h80000000}.
REQ-035 Divisor 0 -> ready_o after E1, result_o = 64'h0; holding start_i keeps ready_o=1; dropping start_i -> FREE next edge.
REQ-036 annul_i pulsed at step 10 -> FREE next edge, ready_o never rises; a new start after that completes normally.
REQ-037 reset asserted mid-ON at step 20 -> FREE with all outputs 0 next edge; a subsequent 100/7 completes in 33 cycles.
REQ-038 Macro off: signed_div_i=1, 32'hFFFFFFF9 / 2 -> quotient 32'h7FFFFFFC, remainder 1.
